mod4_add_arbiter: RTL and testbench
===================================

MOD4_ADD_ARBITER -- requirements
Module: mod4_add_arbiter

Interface
REQ-001 SHALL have parameter TAG_DEPTH, default 4, giving the maximum number of issued-but-unreturned additions (power of 2, >=2).
REQ-002 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports reqN_tdata  in  32  operand pair, a=[31:16], b=[15:0], Q2.14 (N=0,1).
REQ-005 SHALL have ports reqN_tsign  in  1  1=signed add, 0=unsigned, qualified by reqN_tvalid.
REQ-006 SHALL have ports reqN_tvalid in 1 / reqN_tready out 1  requester handshake.
REQ-007 SHALL have ports resN_tdata out 16, resN_overflow out 1, resN_tvalid out 1, resN_tready in 1  per-requester result stream.
REQ-008 SHALL have ports add_tdata_a/add_tdata_b out 16, add_tvalid_a/add_tvalid_b out 1, add_tready_a/add_tready_b in 1  adder operand streams.
REQ-009 SHALL have port add_sign  out  1  signedness driven to the shared adder.
REQ-010 SHALL have ports add_res_tdata in 16, add_res_overflow in 1, add_res_tvalid in 1, add_res_tready out 1  adder result stream.

Function
REQ-011 SHALL implement states IDLE, DRAIN, ISSUE.
REQ-012 IDLE: if any reqN_tvalid and tag FIFO not full, SHALL grant round-robin (pointer priority, then other); pointer reset value selects req0.
REQ-013 IDLE with grant: sign equal to add_sign -> ISSUE; sign different -> DRAIN; FIFO full -> stay IDLE, no grant.
REQ-014 DRAIN: when tag FIFO empty, SHALL load add_sign from granted reqN_tsign and go to ISSUE next cycle; add_sign SHALL never change while FIFO non-empty.
REQ-015 ISSUE: SHALL drive add_tdata_a/b from granted reqN_tdata and hold add_tvalid_a/b high until each lane's own handshake completes; completed lane valid drops next cycle.
REQ-016 ISSUE completes in the cycle the last outstanding lane handshakes (both may complete in one cycle): reqN_tready=1 for exactly that cycle, granted index pushed to tag FIFO, pointer set to the other requester, next state IDLE.
REQ-017 Grant and sign SHALL stay locked through DRAIN and ISSUE; reqN_tready SHALL be 0 at all other times; minimum issue interval 2 cycles.
REQ-018 resN_tvalid SHALL equal add_res_tvalid AND FIFO non-empty AND head==N; resN_tdata/resN_overflow SHALL pass add_res_tdata/add_res_overflow combinationally.
REQ-019 add_res_tready SHALL equal FIFO non-empty AND res[head]_tready; pop on add_res_tvalid AND add_res_tready.
REQ-020 Simultaneous push and pop SHALL leave occupancy unchanged; push when full and pop when empty SHALL be impossible by construction.
REQ-021 A result arriving with FIFO empty SHALL not be accepted (add_res_tready=0, no resN_tvalid).

Reset
REQ-022 On reset: state IDLE, pointer=0, FIFO empty, add_sign=1, lane-done flags 0; reqN_tready, add_tvalid_a/b, resN_tvalid, add_res_tready all 0 the following cycle.
REQ-023 Reset mid-operation SHALL discard all tags and the in-progress issue; the integrator SHALL reset the shared adder in the same cycle (add reset_n = ~reset).

Structure
REQ-024 Package mod4_arb_pkg SHALL hold the state enum, DATA_W=16, FRAC_W=14, and the TAG_DEPTH default.
REQ-025 Tag storage SHALL be sub-module mod4_tag_fifo (1-bit-wide synchronous FIFO, depth TAG_DEPTH, full/empty/count outputs).

Verification
REQ-026 req0 only, sign=1, a=0x2000, b=0x1000 -> res0_tdata=0x3000, res0_overflow=0; res1_tvalid never 1.
REQ-027 req0 sign=1, a=0x6000, b=0x6000 -> res0_overflow=1; req0 sign=1, a=0xE000, b=0x1000 -> res0_tdata=0xF000.
REQ-028 both requesters valid continuously, same sign -> grants 0,1,0,1,...; each result on its own port in issue order.
REQ-029 req0 sign=1 in flight, then req1 sign=0 -> add_sign stays 1 until req0 result pops, becomes 0 before add_tvalid_a rises for req1.
REQ-030 res0_tready=0, four req0 transactions issued -> fifth not granted (req0_tready=0) until one pop; add_tready_b delayed 3 cycles after a -> single req0_tready pulse, one push.
REQ-031 reset asserted during ISSUE -> next cycle all outputs at REQ-022 values, add_sign=1, FIFO empty.

Source files
------------

// File: rtl/mod4_arb_pkg.sv
// Shared types and constants for the mod-4 adder arbiter slice.
package mod4_arb_pkg;

  localparam int DATA_W        = 16;  // Q2.14 operand / result width
  localparam int FRAC_W        = 14;
  localparam int TAG_DEPTH_DEF = 4;   // default issued-but-unreturned limit
  localparam int NUM_REQ       = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    ISSUE = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } op_t;

  // Requester tdata packs a in the upper half, b in the lower half.
  function automatic op_t split_ops(input logic [2*DATA_W-1:0] tdata);
    op_t o;
    o.a = tdata[2*DATA_W-1:DATA_W];
    o.b = tdata[DATA_W-1:0];
    return o;
  endfunction

endpackage

// File: rtl/mod4_tag_fifo.sv
// 1-bit tag FIFO: records which requester owns each in-flight addition.
module mod4_tag_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        din,
  input  logic        pop,
  output logic        dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // The arbiter never pushes when full or pops when empty; gating here keeps
  // the pointers sane even if that ever changes.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Tag storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; push+pop together leave count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mod4_add_arbiter.sv
// Two-requester round-robin front end for one shared Q2.14 adder. Results
// return in issue order and are steered back by a tag FIFO. The adder's
// signedness only changes once every in-flight addition has drained.
module mod4_add_arbiter
  import mod4_arb_pkg::*;
#(
  parameter int TAG_DEPTH = TAG_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  // requester 0
  input  logic [31:0]       req0_tdata,
  input  logic              req0_tsign,
  input  logic              req0_tvalid,
  output logic              req0_tready,
  // requester 1
  input  logic [31:0]       req1_tdata,
  input  logic              req1_tsign,
  input  logic              req1_tvalid,
  output logic              req1_tready,
  // result streams
  output logic [DATA_W-1:0] res0_tdata,
  output logic              res0_overflow,
  output logic              res0_tvalid,
  input  logic              res0_tready,
  output logic [DATA_W-1:0] res1_tdata,
  output logic              res1_overflow,
  output logic              res1_tvalid,
  input  logic              res1_tready,
  // shared adder operand streams
  output logic [DATA_W-1:0] add_tdata_a,
  output logic              add_tvalid_a,
  input  logic              add_tready_a,
  output logic [DATA_W-1:0] add_tdata_b,
  output logic              add_tvalid_b,
  input  logic              add_tready_b,
  output logic              add_sign,
  // shared adder result stream
  input  logic [DATA_W-1:0] add_res_tdata,
  input  logic              add_res_overflow,
  input  logic              add_res_tvalid,
  output logic              add_res_tready
);

  localparam int AW = $clog2(TAG_DEPTH);

  state_t state, state_nx;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0][31:0]  req_data;
  logic [NUM_REQ-1:0]        req_sign;
  logic [NUM_REQ-1:0]        res_ready;
  logic [NUM_REQ-1:0]        res_valid;
  logic [NUM_REQ-1:0]        req_ready;

  logic ptr;        // round-robin priority
  logic gnt;        // locked grant index
  logic gsign;      // locked sign of the grant
  logic pick;
  logic grant;
  logic done_a, done_b;
  logic hs_a, hs_b;
  logic issue_done;
  op_t  ops;

  logic          tag_full, tag_empty, tag_head, tag_valid, tag_pop;
  logic [AW:0]   tag_count;

  assign req_valid = {req1_tvalid, req0_tvalid};
  assign req_data  = {req1_tdata,  req0_tdata};
  assign req_sign  = {req1_tsign,  req0_tsign};
  assign res_ready = {res1_tready, res0_tready};

  // Pointer side wins, otherwise the other requester.
  assign pick  = req_valid[ptr] ? ptr : ~ptr;
  assign grant = (state == IDLE) & (|req_valid) & ~tag_full;

  // Each operand lane holds valid until its own handshake.
  assign add_tvalid_a = (state == ISSUE) & ~done_a;
  assign add_tvalid_b = (state == ISSUE) & ~done_b;
  assign hs_a         = add_tvalid_a & add_tready_a;
  assign hs_b         = add_tvalid_b & add_tready_b;
  assign issue_done   = (state == ISSUE) & (done_a | hs_a) & (done_b | hs_b);

  assign ops         = split_ops(req_data[gnt]);
  assign add_tdata_a = ops.a;
  assign add_tdata_b = ops.b;

  assign req_ready   = issue_done ? (NUM_REQ'(1) << gnt) : '0;
  assign req0_tready = req_ready[0];
  assign req1_tready = req_ready[1];

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant) state_nx = (req_sign[pick] == add_sign) ? ISSUE : DRAIN;
      DRAIN:   if (tag_empty) state_nx = ISSUE;
      ISSUE:   if (issue_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Grant lock, adder sign, round-robin pointer and per-lane done flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= 1'b0;
      gnt      <= 1'b0;
      gsign    <= 1'b1;
      add_sign <= 1'b1;
      done_a   <= 1'b0;
      done_b   <= 1'b0;
    end else begin
      if (grant) begin
        gnt   <= pick;
        gsign <= req_sign[pick];
      end
      if (state == DRAIN && tag_empty) add_sign <= gsign;
      if (issue_done) begin
        ptr    <= ~gnt;
        done_a <= 1'b0;
        done_b <= 1'b0;
      end else begin
        done_a <= done_a | hs_a;
        done_b <= done_b | hs_b;
      end
    end
  end

  mod4_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tags (
    .clk   (clk),
    .reset (reset),
    .push  (issue_done),
    .din   (gnt),
    .pop   (tag_pop),
    .dout  (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  // Results are only accepted while a tag is outstanding to steer them.
  assign tag_valid      = (tag_count != '0);
  assign add_res_tready = tag_valid & res_ready[tag_head];
  assign tag_pop        = add_res_tvalid & add_res_tready;

  for (genvar n = 0; n < NUM_REQ; n++) begin : g_res
    assign res_valid[n] = add_res_tvalid & tag_valid & (tag_head == 1'(n));
  end

  assign res0_tvalid   = res_valid[0];
  assign res1_tvalid   = res_valid[1];
  assign res0_tdata    = add_res_tdata;
  assign res1_tdata    = add_res_tdata;
  assign res0_overflow = add_res_overflow;
  assign res1_overflow = add_res_overflow;

endmodule

// File: tb/tb_mod4_add_arbiter.sv
// Bench for mod4_add_arbiter: acts as both requesters and the shared adder,
// scoreboarding each requester's results in issue order.
module tb_mod4_add_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] req0_tdata, req1_tdata;
  logic        req0_tsign, req1_tsign, req0_tvalid, req1_tvalid;
  logic        req0_tready, req1_tready;
  logic [15:0] res0_tdata, res1_tdata;
  logic        res0_overflow, res1_overflow, res0_tvalid, res1_tvalid;
  logic        res0_tready, res1_tready;
  logic [15:0] add_tdata_a, add_tdata_b;
  logic        add_tvalid_a, add_tvalid_b, add_tready_a, add_tready_b, add_sign;
  logic [15:0] add_res_tdata;
  logic        add_res_overflow, add_res_tvalid, add_res_tready;

  always #5 clk = ~clk;

  mod4_add_arbiter #(.TAG_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .req0_tdata(req0_tdata), .req0_tsign(req0_tsign), .req0_tvalid(req0_tvalid), .req0_tready(req0_tready),
    .req1_tdata(req1_tdata), .req1_tsign(req1_tsign), .req1_tvalid(req1_tvalid), .req1_tready(req1_tready),
    .res0_tdata(res0_tdata), .res0_overflow(res0_overflow), .res0_tvalid(res0_tvalid), .res0_tready(res0_tready),
    .res1_tdata(res1_tdata), .res1_overflow(res1_overflow), .res1_tvalid(res1_tvalid), .res1_tready(res1_tready),
    .add_tdata_a(add_tdata_a), .add_tvalid_a(add_tvalid_a), .add_tready_a(add_tready_a),
    .add_tdata_b(add_tdata_b), .add_tvalid_b(add_tvalid_b), .add_tready_b(add_tready_b),
    .add_sign(add_sign),
    .add_res_tdata(add_res_tdata), .add_res_overflow(add_res_overflow),
    .add_res_tvalid(add_res_tvalid), .add_res_tready(add_res_tready)
  );

  typedef struct { logic [15:0] d; logic ovf; } exp_t;
  typedef struct { logic sign; logic [15:0] a; logic [15:0] b; exp_t e; } rq_t;
  typedef struct { int req; logic sign; logic [15:0] a; logic [15:0] b; logic [15:0] d; logic ovf; } vec_t;

  rq_t  rq0[$], rq1[$];
  exp_t eq0[$], eq1[$], aq[$];
  int   glog[$];
  logic [15:0] cap_a, cap_b;
  bit   have_a, have_b, a_seen;
  int   b_delay, bcnt;
  int   tests, fails, hs0, hs1, rdy0_pulses, viol;
  logic [16:0] last0, last1;

  // Reference Q2.14 add: signed overflow on same-sign inputs flipping sign,
  // unsigned overflow on carry out.
  function automatic exp_t golden(input logic s, input logic [15:0] a, input logic [15:0] b);
    exp_t r;
    logic [16:0] sum;
    sum   = {1'b0, a} + {1'b0, b};
    r.d   = sum[15:0];
    r.ovf = s ? ((a[15] == b[15]) && (sum[15] != a[15])) : sum[16];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_req(input int n, input logic s, input logic [15:0] a, input logic [15:0] b);
    rq_t r;
    r.sign = s; r.a = a; r.b = b; r.e = golden(s, a, b);
    if (n == 0) rq0.push_back(r); else rq1.push_back(r);
  endtask

  // One clock: sample/score at negedge, update models and drives after posedge.
  task automatic tick();
    bit h0, h1, ha, hb, hr;
    exp_t e;
    @(negedge clk);
    h0 = req0_tvalid & req0_tready;
    h1 = req1_tvalid & req1_tready;
    ha = add_tvalid_a & add_tready_a;
    hb = add_tvalid_b & add_tready_b;
    hr = add_res_tvalid & add_res_tready;
    if (add_tvalid_a && a_seen) viol++;
    if (req0_tready) rdy0_pulses++;
    if (res0_tvalid) begin
      tests++;
      if (eq0.size() == 0) begin fails++; $display("FAIL res0_unexpected: got valid data %h expected no result", res0_tdata); end
      else if (res0_tready) begin
        e = eq0.pop_front();
        last0 = {res0_overflow, res0_tdata};
        if ({res0_overflow, res0_tdata} !== {e.ovf, e.d}) begin
          fails++; $display("FAIL res0_data: got %h expected %h", {res0_overflow, res0_tdata}, {e.ovf, e.d});
        end
      end
    end
    if (res1_tvalid) begin
      tests++;
      if (eq1.size() == 0) begin fails++; $display("FAIL res1_unexpected: got valid data %h expected no result", res1_tdata); end
      else if (res1_tready) begin
        e = eq1.pop_front();
        last1 = {res1_overflow, res1_tdata};
        if ({res1_overflow, res1_tdata} !== {e.ovf, e.d}) begin
          fails++; $display("FAIL res1_data: got %h expected %h", {res1_overflow, res1_tdata}, {e.ovf, e.d});
        end
      end
    end
    @(posedge clk);
    #1;
    if (reset) begin
      rq0.delete(); rq1.delete(); eq0.delete(); eq1.delete(); aq.delete();
      have_a = 0; have_b = 0; a_seen = 0; bcnt = 0;
    end else begin
      if (hr) void'(aq.pop_front());
      if (ha) begin cap_a = add_tdata_a; have_a = 1; a_seen = 1; end
      if (hb) begin cap_b = add_tdata_b; have_b = 1; bcnt = 0; end
      else if (add_tvalid_b) bcnt++;
      if (h0) begin eq0.push_back(rq0[0].e); void'(rq0.pop_front()); glog.push_back(0); hs0++; a_seen = 0; end
      if (h1) begin eq1.push_back(rq1[0].e); void'(rq1.pop_front()); glog.push_back(1); hs1++; a_seen = 0; end
      if (have_a && have_b) begin
        aq.push_back(golden(add_sign, cap_a, cap_b));
        have_a = 0; have_b = 0;
      end
    end
    req0_tvalid = (rq0.size() > 0);
    if (rq0.size() > 0) begin req0_tdata = {rq0[0].a, rq0[0].b}; req0_tsign = rq0[0].sign; end
    req1_tvalid = (rq1.size() > 0);
    if (rq1.size() > 0) begin req1_tdata = {rq1[0].a, rq1[0].b}; req1_tsign = rq1[0].sign; end
    add_res_tvalid = (aq.size() > 0);
    if (aq.size() > 0) begin add_res_tdata = aq[0].d; add_res_overflow = aq[0].ovf; end
    add_tready_a = 1'b1;
    add_tready_b = (bcnt >= b_delay);
    #1;
  endtask

  task automatic run_until_idle(input string nm, input int max);
    int n = 0;
    while ((rq0.size() + rq1.size() + eq0.size() + eq1.size() + aq.size()) != 0 || have_a || have_b) begin
      if (n >= max) break;
      tick();
      n++;
    end
    tests++;
    if (n >= max) begin fails++; $display("FAIL %s_timeout: got %0d cycles expected under %0d", nm, n, max); end
  endtask

  vec_t vecs[9];

  initial begin
    tests = 0; fails = 0; hs0 = 0; hs1 = 0; viol = 0; rdy0_pulses = 0;
    b_delay = 0; bcnt = 0; have_a = 0; have_b = 0; a_seen = 0;
    last0 = '0; last1 = '0;
    reset = 1'b1;
    req0_tdata = '0; req1_tdata = '0; req0_tsign = 1'b0; req1_tsign = 1'b0;
    req0_tvalid = 1'b0; req1_tvalid = 1'b0;
    res0_tready = 1'b1; res1_tready = 1'b1;
    add_tready_a = 1'b1; add_tready_b = 1'b1;
    add_res_tdata = '0; add_res_overflow = 1'b0; add_res_tvalid = 1'b0;

    vecs[0] = '{0, 1'b1, 16'h2000, 16'h1000, 16'h3000, 1'b0};
    vecs[1] = '{0, 1'b1, 16'h6000, 16'h6000, 16'hC000, 1'b1};
    vecs[2] = '{0, 1'b1, 16'hE000, 16'h1000, 16'hF000, 1'b0};
    vecs[3] = '{0, 1'b0, 16'hF000, 16'h2000, 16'h1000, 1'b1};
    vecs[4] = '{0, 1'b0, 16'h1234, 16'h1111, 16'h2345, 1'b0};
    vecs[5] = '{1, 1'b1, 16'h8000, 16'h8000, 16'h0000, 1'b1};
    vecs[6] = '{1, 1'b1, 16'h7FFF, 16'h0001, 16'h8000, 1'b1};
    vecs[7] = '{1, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
    vecs[8] = '{1, 1'b1, 16'hC000, 16'h2000, 16'hE000, 1'b0};

    // Reset state.
    tick(); tick();
    chk("rst_req0_tready", {31'b0, req0_tready}, 0);
    chk("rst_req1_tready", {31'b0, req1_tready}, 0);
    chk("rst_add_tvalid", {30'b0, add_tvalid_a, add_tvalid_b}, 0);
    chk("rst_res_tvalid", {30'b0, res0_tvalid, res1_tvalid}, 0);
    chk("rst_add_res_tready", {31'b0, add_res_tready}, 0);
    chk("rst_add_sign", {31'b0, add_sign}, 1);
    reset = 1'b0;
    tick();

    // Both requesters busy with one sign: strict alternation starting at req0.
    for (int i = 0; i < 4; i++) begin
      push_req(0, 1'b1, 16'(16'h0100 * i), 16'h0010);
      push_req(1, 1'b1, 16'h1000, 16'(16'h0001 * i));
    end
    glog.delete();
    run_until_idle("alternate", 200);
    chk("alt_count", glog.size(), 8);
    for (int i = 0; i < glog.size() && i < 8; i++) chk($sformatf("alt_grant%0d", i), glog[i], i % 2);

    // Table vectors, one at a time, checked against constant expectations.
    for (int i = 0; i < 9; i++) begin
      rq_t r;
      r.sign = vecs[i].sign; r.a = vecs[i].a; r.b = vecs[i].b;
      r.e.d = vecs[i].d; r.e.ovf = vecs[i].ovf;
      if (vecs[i].req == 0) rq0.push_back(r); else rq1.push_back(r);
      run_until_idle($sformatf("vec%0d", i), 100);
      if (vecs[i].req == 0) chk($sformatf("vec%0d_res0", i), {15'b0, last0}, {15'b0, vecs[i].ovf, vecs[i].d});
      else                  chk($sformatf("vec%0d_res1", i), {15'b0, last1}, {15'b0, vecs[i].ovf, vecs[i].d});
    end

    // Sign change waits for the in-flight signed result to pop.
    res0_tready = 1'b0;
    push_req(0, 1'b1, 16'h0400, 16'h0400);
    for (int i = 0; i < 4; i++) tick();
    push_req(1, 1'b0, 16'h9000, 16'h8000);
    for (int i = 0; i < 6; i++) tick();
    chk("drain_sign_held", {31'b0, add_sign}, 1);
    chk("drain_no_issue", {31'b0, add_tvalid_a}, 0);
    res0_tready = 1'b1;
    begin
      int n = 0;
      while (!add_tvalid_a && n < 20) begin tick(); n++; end
      chk("drain_issue_seen", {31'b0, add_tvalid_a}, 1);
      chk("drain_sign_new", {31'b0, add_sign}, 0);
      chk("drain_res0_popped", eq0.size(), 0);
    end
    run_until_idle("drain", 100);

    // Tag FIFO full blocks a fifth grant; slow b lane gives one ready pulse.
    res0_tready = 1'b0;
    hs0 = 0;
    for (int i = 0; i < 5; i++) push_req(0, 1'b0, 16'(16'h0011 * (i + 1)), 16'h0100);
    for (int i = 0; i < 20; i++) tick();
    chk("full_issued", hs0, 4);
    chk("full_req0_tready", {31'b0, req0_tready}, 0);
    chk("full_req0_waiting", {31'b0, req0_tvalid}, 1);
    b_delay = 3; viol = 0;
    res0_tready = 1'b1;
    tick();
    res0_tready = 1'b0;
    rdy0_pulses = 0;
    for (int i = 0; i < 12; i++) tick();
    chk("slowb_issued", hs0, 5);
    chk("slowb_ready_pulses", rdy0_pulses, 1);
    chk("slowb_lane_a_drop", viol, 0);
    b_delay = 0;
    res0_tready = 1'b1;
    run_until_idle("full", 200);

    // Reset in the middle of an issue (add_sign moved to 0 first).
    b_delay = 10;
    push_req(0, 1'b0, 16'h0001, 16'h0002);
    begin
      int n = 0;
      while (!(add_tvalid_b && !add_tvalid_a) && n < 20) begin tick(); n++; end
      chk("mid_issue_reached", {30'b0, add_tvalid_a, add_tvalid_b}, 1);
      chk("mid_issue_sign", {31'b0, add_sign}, 0);
    end
    reset = 1'b1;
    tick();
    chk("mid_rst_req_tready", {30'b0, req0_tready, req1_tready}, 0);
    chk("mid_rst_add_tvalid", {30'b0, add_tvalid_a, add_tvalid_b}, 0);
    chk("mid_rst_res_tvalid", {30'b0, res0_tvalid, res1_tvalid}, 0);
    chk("mid_rst_add_sign", {31'b0, add_sign}, 1);
    reset = 1'b0;
    b_delay = 0;
    tick();
    // A stray adder result must be refused while no tag is outstanding.
    add_res_tdata = 16'h1234; add_res_overflow = 1'b0; add_res_tvalid = 1'b1;
    #1;
    chk("empty_add_res_tready", {31'b0, add_res_tready}, 0);
    chk("empty_res_tvalid", {30'b0, res0_tvalid, res1_tvalid}, 0);
    add_res_tvalid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
